// File: rtl/hdlc_pkg.sv
// Shared definitions for the HDLC transmit framer: FSM encoding, flag/CRC
// constants and the serial CRC-16/X.25 step function.
package hdlc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_OPEN  = 3'd1,
    ST_DATA  = 3'd2,
    ST_FCS   = 3'd3,
    ST_CLOSE = 3'd4,
    ST_ABORT = 3'd5
  } state_t;

  localparam logic [7:0]  HDLC_FLAG   = 8'h7E;
  localparam logic [15:0] CRC16_POLY  = 16'h8408;
  localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
  localparam logic [2:0]  STUFF_LIMIT = 3'd5;

  // Reflected (LSB-first) CRC update for one bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[0] ^ b;
    return (crc >> 1) ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/hdlc_crc16.sv
// Serial CRC-16/X.25 register: one payload bit per enabled cycle, LSB first.
module hdlc_crc16
  import hdlc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || init) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= crc16_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/hdlc_tx_framer.sv
// HDLC bit-level transmit framer: flags, zero stuffing, optional FCS-16.
// Optional FCS is enabled by defining HDLC_TX_FCS_EN.
module hdlc_tx_framer
  import hdlc_pkg::*;
#(
  parameter int unsigned N_OPEN_FLAGS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       data_out,
  output logic       activity,
  output logic       underrun,
  output logic       busy,
  output state_t     fsm_state
);

  localparam logic [3:0] LAST_FLAG = 4'(N_OPEN_FLAGS - 1);

  state_t     state, state_next;
  logic [7:0] hold_data, shift_q, shift_next;
  logic       hold_full, hold_last, shift_last, shift_last_next;
  logic [3:0] bit_cnt, bit_next, flag_cnt, flag_next;
  logic [2:0] ones_cnt, ones_next;
  logic       end_pending, end_next;
  logic       line_bit, line_act, take_hold, clear_hold, finish;
  logic       accept, stuff_now, seg_last, fcs_bit;

  // Handshake: a byte moves into the holding register on any cycle where
  // tx_valid && tx_ready; tx_ready only reflects holding-register emptiness.
  assign tx_ready  = !hold_full;
  assign accept    = tx_valid && !hold_full;
  assign stuff_now = (ones_cnt == STUFF_LIMIT);
  assign seg_last  = (state == ST_FCS) ? (bit_cnt == 4'd15) : (bit_cnt == 4'd7);
  assign fsm_state = state;

`ifdef HDLC_TX_FCS_EN
  logic [15:0] crc;
  logic        crc_init, crc_en;
  assign crc_init = (state == ST_OPEN);
  assign crc_en   = (state == ST_DATA) && !stuff_now;
  assign fcs_bit  = ~crc[bit_cnt];

  hdlc_crc16 u_crc (
    .clk    (clk),
    .rst    (rst),
    .init   (crc_init),
    .en     (crc_en),
    .bit_in (shift_q[0]),
    .crc    (crc)
  );
`else
  assign fcs_bit = 1'b0;
`endif

  always_comb begin
    state_next      = state;
    line_bit        = 1'b0;
    line_act        = 1'b0;
    bit_next        = bit_cnt;
    flag_next       = flag_cnt;
    ones_next       = ones_cnt;
    end_next        = end_pending;
    shift_next      = shift_q;
    shift_last_next = shift_last;
    take_hold       = 1'b0;
    clear_hold      = 1'b0;
    finish          = 1'b0;
    case (state)
      ST_IDLE: begin
        bit_next  = 4'd0;
        flag_next = 4'd0;
        ones_next = 3'd0;
        end_next  = 1'b0;
        if (hold_full || accept) state_next = ST_OPEN;
      end
      ST_OPEN: begin
        line_act = 1'b1;
        line_bit = HDLC_FLAG[bit_cnt[2:0]];
        bit_next = bit_cnt + 4'd1;
        if (bit_cnt == 4'd7) begin
          bit_next = 4'd0;
          if (flag_cnt == LAST_FLAG) begin
            take_hold  = 1'b1;
            ones_next  = 3'd0;
            end_next   = 1'b0;
            state_next = ST_DATA;
          end else begin
            flag_next = flag_cnt + 4'd1;
          end
        end
      end
      ST_DATA, ST_FCS: begin
        line_act = 1'b1;
        if (stuff_now) begin
          // Inserted zero: shifter and bit counter hold for this cycle.
          line_bit  = 1'b0;
          ones_next = 3'd0;
          finish    = end_pending;
        end else begin
          line_bit  = (state == ST_FCS) ? fcs_bit : shift_q[0];
          ones_next = line_bit ? ones_cnt + 3'd1 : 3'd0;
          bit_next  = bit_cnt + 4'd1;
          if (state == ST_DATA) shift_next = {1'b0, shift_q[7:1]};
          if (seg_last) begin
            bit_next = 4'd0;
            if (ones_next == STUFF_LIMIT) end_next = 1'b1;
            else finish = 1'b1;
          end
        end
        if (finish) begin
          end_next = 1'b0;
          if (state == ST_FCS) begin
            state_next = ST_CLOSE;
            ones_next  = 3'd0;
          end else if (shift_last) begin
`ifdef HDLC_TX_FCS_EN
            state_next = ST_FCS;
`else
            state_next = ST_CLOSE;
            ones_next  = 3'd0;
`endif
          end else if (hold_full) begin
            take_hold = 1'b1;
          end else begin
            state_next = ST_ABORT;
            clear_hold = 1'b1;
          end
        end
      end
      ST_CLOSE: begin
        line_act = 1'b1;
        line_bit = HDLC_FLAG[bit_cnt[2:0]];
        bit_next = bit_cnt + 4'd1;
        if (bit_cnt == 4'd7) begin
          bit_next   = 4'd0;
          state_next = ST_IDLE;
        end
      end
      ST_ABORT: begin
        line_act = 1'b1;
        line_bit = 1'b1;
        bit_next = bit_cnt + 4'd1;
        if (bit_cnt == 4'd7) begin
          bit_next   = 4'd0;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (take_hold) begin
      shift_next      = hold_data;
      shift_last_next = hold_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      hold_data   <= 8'h00;
      hold_full   <= 1'b0;
      hold_last   <= 1'b0;
      shift_q     <= 8'h00;
      shift_last  <= 1'b0;
      bit_cnt     <= 4'd0;
      flag_cnt    <= 4'd0;
      ones_cnt    <= 3'd0;
      end_pending <= 1'b0;
      data_out    <= 1'b0;
      activity    <= 1'b0;
      underrun    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      shift_q     <= shift_next;
      shift_last  <= shift_last_next;
      bit_cnt     <= bit_next;
      flag_cnt    <= flag_next;
      ones_cnt    <= ones_next;
      end_pending <= end_next;
      data_out    <= line_bit;
      activity    <= line_act;
      // Lines up with the first abort 1 on data_out.
      underrun    <= (state == ST_ABORT) && (bit_cnt == 4'd0);
      busy        <= (state_next != ST_IDLE);
      if (accept) begin
        hold_full <= 1'b1;
        hold_data <= tx_data;
        hold_last <= tx_last;
      end
      if (take_hold) hold_full <= 1'b0;
      if (clear_hold) begin
        hold_full <= 1'b0;
        hold_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Self-checking bench for hdlc_tx_framer: frame-level line model, per-bit
// compare on every active cycle, and hand-computed literal frame checks.
module tb_hdlc_tx_framer;
  import hdlc_pkg::*;

  localparam int N_FLAGS = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid, tx_last;
  logic       tx_ready, data_out, activity, underrun, busy;
  state_t     fsm_state;

  always #5 clk = ~clk;

  hdlc_tx_framer #(.N_OPEN_FLAGS(N_FLAGS)) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_last   (tx_last),
    .tx_ready  (tx_ready),
    .data_out  (data_out),
    .activity  (activity),
    .underrun  (underrun),
    .busy      (busy),
    .fsm_state (fsm_state)
  );

  // exp_q entries: {expected underrun, expected line bit}
  logic [1:0] exp_q[$];
  logic       cap_q[$];
  logic [7:0] pay_q[$];
  logic [7:0] rx_q[$];
  int errors = 0;
  int checks = 0;
  int run_len = 0, last_run = 0, gap_cnt = 0, last_gap = 0, under_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Compare process: every active line bit against the model stream.
  always @(negedge clk) begin
    logic [1:0] e;
    if (rst === 1'b0) begin
      if (activity === 1'b1) begin
        if (run_len == 0) last_gap = gap_cnt;
        run_len++;
        cap_q.push_back(data_out);
        if (underrun === 1'b1) under_cnt++;
        if (exp_q.size() == 0) begin
          check("extra_line_bit", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("line_bit", data_out, e[0]);
          check("underrun", underrun, e[1]);
        end
      end else begin
        check("idle_outputs", {activity, underrun, data_out}, 3'b000);
        if (run_len != 0) begin
          last_run = run_len;
          run_len  = 0;
          gap_cnt  = 0;
        end
        gap_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 16'h8408;
      else c = c >> 1;
    end
    return c;
  endfunction

  // Builds the expected line stream of one frame from pay_q.
  task automatic model_frame(input bit with_last);
    logic       raw[$];
    logic [7:0] flag;
    int         ones;
    flag = 8'h7E;
    for (int f = 0; f < N_FLAGS; f++)
      for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, flag[i]});
    foreach (pay_q[k])
      for (int i = 0; i < 8; i++) raw.push_back(pay_q[k][i]);
`ifdef HDLC_TX_FCS_EN
    if (with_last) begin
      logic [15:0] c;
      c = 16'hFFFF;
      foreach (pay_q[k]) c = crc_byte(c, pay_q[k]);
      c = ~c;
      for (int i = 0; i < 16; i++) raw.push_back(c[i]);
    end
`endif
    ones = 0;
    foreach (raw[k]) begin
      exp_q.push_back({1'b0, raw[k]});
      ones = raw[k] ? ones + 1 : 0;
      if (ones == 5) begin
        exp_q.push_back(2'b00);
        ones = 0;
      end
    end
    if (with_last) begin
      for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, flag[i]});
    end else begin
      for (int i = 0; i < 8; i++) exp_q.push_back({(i == 0), 1'b1});
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int w;
    w = 0;
    tx_data  = d;
    tx_last  = last;
    tx_valid = 1'b1;
    while (!tx_ready && w < 300) begin
      tick();
      w++;
    end
    check("send_ready", tx_ready, 1'b1);
    tick();
    tx_valid = 1'b0;
    tx_last  = 1'b0;
  endtask

  task automatic send_payload(input bit with_last);
    foreach (pay_q[k]) send_byte(pay_q[k], with_last && (k == pay_q.size() - 1));
  endtask

  task automatic wait_done(input string name);
    int w;
    w = 0;
    while ((exp_q.size() != 0 || activity || busy) && w < 2000) begin
      tick();
      w++;
    end
    check(name, exp_q.size(), 0);
    tick();
  endtask

  // Receiver view: strip flags and closing octet, remove stuffed zeros.
  task automatic destuff();
    logic [7:0] b;
    int k, ones;
    rx_q.delete();
    b = 8'h00;
    k = 0;
    ones = 0;
    for (int i = N_FLAGS * 8; i < cap_q.size() - 8; i++) begin
      if (ones == 5) begin
        ones = 0;
      end else begin
        b[k] = cap_q[i];
        ones = cap_q[i] ? ones + 1 : 0;
        k++;
        if (k == 8) begin
          rx_q.push_back(b);
          k = 0;
        end
      end
    end
  endtask

  task automatic check_payload(input string name);
    destuff();
    foreach (pay_q[k]) begin
      if (k < rx_q.size()) check(name, rx_q[k], pay_q[k]);
      else check(name, rx_q.size(), pay_q.size());
    end
  endtask

  function automatic logic [63:0] cap_vec();
    logic [63:0] v;
    v = 64'd0;
    foreach (cap_q[k]) v = {v[62:0], cap_q[k]};
    return v;
  endfunction

  task automatic check_reset_outputs(input string name);
    check({name, "_data_out"}, data_out, 1'b0);
    check({name, "_activity"}, activity, 1'b0);
    check({name, "_underrun"}, underrun, 1'b0);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_tx_ready"}, tx_ready, 1'b1);
  endtask

  task automatic frame_zero(input string name);
    pay_q = '{8'h00};
    model_frame(1);
    cap_q.delete();
    tx_data  = 8'h00;
    tx_last  = 1'b1;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    check({name, "_busy_t1"}, busy, 1'b1);
    check({name, "_act_t1"}, activity, 1'b0);
    tick();
    check({name, "_act_t2"}, activity, 1'b1);
    check({name, "_first_bit"}, data_out, 1'b0);
    wait_done({name, "_done"});
    check_payload({name, "_payload"});
`ifndef HDLC_TX_FCS_EN
    check({name, "_len"}, last_run, 24);
    check({name, "_bits"}, cap_vec(), 64'(24'b011111100000000001111110));
`endif
  endtask

  initial begin
    int u0;
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    frame_zero("f00");

`ifndef HDLC_TX_FCS_EN
    pay_q = '{8'hFF};
    model_frame(1);
    cap_q.delete();
    send_payload(1);
    wait_done("fff_done");
    check("fff_len", last_run, 25);
    check("fff_bits", cap_vec(), 64'(25'b0111111011111011101111110));
    check_payload("fff_payload");
`else
    begin
      logic [15:0] c, fcs, r;
      pay_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      c = 16'hFFFF;
      foreach (pay_q[k]) c = crc_byte(c, pay_q[k]);
      fcs = ~c;
      check("model_fcs", fcs, 16'h906E);
      r = crc_byte(crc_byte(c, fcs[7:0]), fcs[15:8]);
      check("model_residual", r, 16'hF0B8);
      model_frame(1);
      cap_q.delete();
      send_payload(1);
      wait_done("crc_done");
      check_payload("crc_payload");
      check("crc_rx_len", rx_q.size(), 11);
      if (rx_q.size() == 11) begin
        check("crc_fcs_lo", rx_q[9], 8'h6E);
        check("crc_fcs_hi", rx_q[10], 8'h90);
      end
    end
`endif

    // Stuffing across byte boundaries and a pending stuff bit at frame end.
    pay_q = '{8'h7E, 8'hFF, 8'hFF, 8'hF8};
    model_frame(1);
    cap_q.delete();
    send_payload(1);
    wait_done("stuff_done");
    check_payload("stuff_payload");

    // Underrun: single byte, no tx_last, nothing follows.
    u0 = under_cnt;
    pay_q = '{8'h55};
    model_frame(0);
    cap_q.delete();
    send_payload(0);
    wait_done("abort_done");
    check("abort_pulses", under_cnt - u0, 1);
    check("abort_len", last_run, 24);
    check("abort_bits", cap_vec(), 64'(24'b011111101010101011111111));
    check("abort_ready", tx_ready, 1'b1);

    // Back-to-back frames presented continuously.
    pay_q = '{8'h12, 8'h34};
    model_frame(1);
    pay_q = '{8'hA5, 8'h7E};
    model_frame(1);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b1);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h7E, 1'b1);
    wait_done("b2b_done");
    check("b2b_gap", last_gap, 1);

    // Reset in the middle of the payload.
    pay_q = '{8'h3C};
    model_frame(1);
    send_byte(8'h3C, 1'b1);
    repeat (12) tick();
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    exp_q.delete();
    cap_q.delete();
    run_len = 0;
    rst = 1'b0;
    tick();

    frame_zero("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
